// File: rtl/reaction_pkg.sv
// Shared types and width helpers for the multi-channel reaction-time lighter.
package reaction_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DELAY = 2'd1,
    LIT   = 2'd2,
    DONE  = 2'd3
  } state_t;

  // Wide enough to hold num*SCALE for every num without truncation.
  function automatic int target_width(input int num_w, input int scale);
    return num_w + $clog2(scale + 1);
  endfunction

  function automatic int sel_width(input int channels);
    return (channels > 1) ? $clog2(channels) : 1;
  endfunction

endpackage

// File: rtl/reaction_lighter_tick_counter.sv
// Clearable up-counter whose terminal flag is asserted on the edge where the
// incremented count reaches i_limit (a limit of 0 behaves like 1).
module tick_counter #(
  parameter int W = 8
) (
  input  logic         i_clk,
  input  logic         i_rst,
  input  logic         i_clear,
  input  logic         i_en,
  input  logic [W-1:0] i_limit,
  output logic [W-1:0] o_count,
  output logic         o_done
);

  logic [W-1:0] r_count;
  logic [W:0]   w_sum;

  assign w_sum   = {1'b0, r_count} + {{W{1'b0}}, 1'b1};
  assign o_done  = (w_sum >= {1'b0, i_limit});
  assign o_count = r_count;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_count <= '0;
    end else if (i_clear) begin
      r_count <= '0;
    end else if (i_en) begin
      r_count <= w_sum[W-1:0];
    end
  end

endmodule

// File: rtl/reaction_lighter.sv
// Lights one of CHANNELS LEDs num*SCALE clocks after a round is accepted, then
// measures the reaction time and flags false starts and timeouts.
module reaction_lighter
  import reaction_pkg::*;
#(
  parameter  int CHANNELS = 4,
  parameter  int NUM_W    = 7,
  parameter  int SCALE    = 20,
  parameter  int RT_W     = 16,
  parameter  int TIMEOUT  = 1000,
  localparam int SEL_W    = sel_width(CHANNELS),
  localparam int TW       = target_width(NUM_W, SCALE)
) (
  input  logic                i_clk,
  input  logic                i_rst,
  input  logic                i_enable,
  input  logic [NUM_W-1:0]    i_num,
  input  logic [SEL_W-1:0]    i_sel,
  input  logic                i_press,
  output logic [CHANNELS-1:0] o_outled,
  output logic                o_enableout,
  output logic [RT_W-1:0]     o_rt_count,
  output logic                o_rt_valid,
  output logic                o_false_start,
  output logic                o_timeout,
  output logic [1:0]          o_dbg_state,
  output logic [TW-1:0]       o_dbg_delay_cnt
);

  state_t              r_state, w_state_nxt;
  logic [TW-1:0]       r_target, w_target;
  logic [SEL_W-1:0]    r_sel, w_sel;

  logic [CHANNELS-1:0] r_outled, w_outled_nxt, w_onehot;
  logic                r_enableout, w_enableout_nxt;
  logic [RT_W-1:0]     r_rt_count, w_rt_count_nxt;
  logic                r_rt_valid, w_rt_valid_nxt;
  logic                r_false_start, w_false_start_nxt;
  logic                r_timeout, w_timeout_nxt;

  logic                w_accept, w_light;
  logic                w_delay_done, w_react_done;
  logic [TW-1:0]       w_delay_cnt;
  logic [RT_W-1:0]     w_react_cnt;

  assign w_target = TW'(i_num) * TW'(SCALE);
  // Out-of-range LED indices fall back to channel 0.
  assign w_sel    = ({1'b0, i_sel} >= (SEL_W + 1)'(CHANNELS)) ? '0 : i_sel;
  assign w_onehot = CHANNELS'(1) << r_sel;

  assign w_accept = (r_state == IDLE) && i_enable;
  assign w_light  = (r_state == DELAY) && i_enable && !i_press && w_delay_done;

  tick_counter #(.W(TW)) u_delay_cnt (
    .i_clk   (i_clk),
    .i_rst   (i_rst),
    .i_clear (w_accept),
    .i_en    (r_state == DELAY),
    .i_limit (r_target),
    .o_count (w_delay_cnt),
    .o_done  (w_delay_done)
  );

  tick_counter #(.W(RT_W)) u_react_cnt (
    .i_clk   (i_clk),
    .i_rst   (i_rst),
    .i_clear (w_light),
    .i_en    (r_state == LIT),
    .i_limit (RT_W'(TIMEOUT)),
    .o_count (w_react_cnt),
    .o_done  (w_react_done)
  );

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state       <= IDLE;
      r_target      <= '0;
      r_sel         <= '0;
      r_outled      <= '0;
      r_enableout   <= 1'b1;
      r_rt_count    <= '0;
      r_rt_valid    <= 1'b0;
      r_false_start <= 1'b0;
      r_timeout     <= 1'b0;
    end else begin
      r_state       <= w_state_nxt;
      if (w_accept) begin
        r_target <= w_target;
        r_sel    <= w_sel;
      end
      r_outled      <= w_outled_nxt;
      r_enableout   <= w_enableout_nxt;
      r_rt_count    <= w_rt_count_nxt;
      r_rt_valid    <= w_rt_valid_nxt;
      r_false_start <= w_false_start_nxt;
      r_timeout     <= w_timeout_nxt;
    end
  end

  // Dropping enable wins over press; press wins over the LED-on and timeout edges.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:  if (i_enable) w_state_nxt = DELAY;
      DELAY: begin
        if (!i_enable)         w_state_nxt = IDLE;
        else if (i_press)      w_state_nxt = DONE;
        else if (w_delay_done) w_state_nxt = LIT;
      end
      LIT: begin
        if (!i_enable)                 w_state_nxt = IDLE;
        else if (i_press || w_react_done) w_state_nxt = DONE;
      end
      DONE:  if (!i_enable) w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  always_comb begin
    w_outled_nxt      = r_outled;
    w_enableout_nxt   = r_enableout;
    w_rt_count_nxt    = r_rt_count;
    w_rt_valid_nxt    = 1'b0;
    w_false_start_nxt = r_false_start;
    w_timeout_nxt     = r_timeout;
    if ((r_state != IDLE) && !i_enable) begin
      w_outled_nxt      = '0;
      w_enableout_nxt   = 1'b1;
      w_false_start_nxt = 1'b0;
      w_timeout_nxt     = 1'b0;
    end else begin
      case (r_state)
        IDLE: if (i_enable) begin
          w_outled_nxt      = '0;
          w_enableout_nxt   = 1'b1;
          w_rt_count_nxt    = '0;
          w_false_start_nxt = 1'b0;
          w_timeout_nxt     = 1'b0;
        end
        DELAY: begin
          if (i_press) begin
            w_false_start_nxt = 1'b1;
          end else if (w_delay_done) begin
            w_outled_nxt    = w_onehot;
            w_enableout_nxt = 1'b0;
          end
        end
        LIT: begin
          if (i_press) begin
            w_rt_count_nxt = w_react_cnt + RT_W'(1);
            w_rt_valid_nxt = 1'b1;
          end else if (w_react_done) begin
            w_rt_count_nxt = RT_W'(TIMEOUT);
            w_timeout_nxt  = 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign o_outled        = r_outled;
  assign o_enableout     = r_enableout;
  assign o_rt_count      = r_rt_count;
  assign o_rt_valid      = r_rt_valid;
  assign o_false_start   = r_false_start;
  assign o_timeout       = r_timeout;
  assign o_dbg_state     = r_state;
  assign o_dbg_delay_cnt = w_delay_cnt;

endmodule

// File: tb/tb_reaction_lighter.sv
// Scoreboard bench for reaction_lighter: rounds are planned from the timing rules,
// expected events are queued, and a negedge monitor pops and compares them.
module tb_reaction_lighter;
  import reaction_pkg::*;

  localparam int CH      = 5;
  localparam int NUM_W   = 7;
  localparam int SCALE   = 20;
  localparam int RT_W    = 16;
  localparam int TIMEOUT = 1000;
  localparam int SEL_W   = sel_width(CH);
  localparam int TW      = target_width(NUM_W, SCALE);
  localparam int W       = 40;

  localparam logic [2:0] EV_LIT = 3'd1;
  localparam logic [2:0] EV_HIT = 3'd2;
  localparam logic [2:0] EV_FS  = 3'd3;
  localparam logic [2:0] EV_TO  = 3'd4;

  localparam int M_HIT   = 0;
  localparam int M_FS    = 1;
  localparam int M_TO    = 2;
  localparam int M_ABORT = 3;

  logic              clk;
  logic              rst;
  logic              enable;
  logic [NUM_W-1:0]  num;
  logic [SEL_W-1:0]  sel;
  logic              press;
  logic [CH-1:0]     outled;
  logic              enableout;
  logic [RT_W-1:0]   rt_count;
  logic              rt_valid;
  logic              false_start;
  logic              timeout;
  logic [1:0]        dbg_state;
  logic [TW-1:0]     dbg_cnt;

  reaction_lighter #(
    .CHANNELS (CH),
    .NUM_W    (NUM_W),
    .SCALE    (SCALE),
    .RT_W     (RT_W),
    .TIMEOUT  (TIMEOUT)
  ) dut (
    .i_clk           (clk),
    .i_rst           (rst),
    .i_enable        (enable),
    .i_num           (num),
    .i_sel           (sel),
    .i_press         (press),
    .o_outled        (outled),
    .o_enableout     (enableout),
    .o_rt_count      (rt_count),
    .o_rt_valid      (rt_valid),
    .o_false_start   (false_start),
    .o_timeout       (timeout),
    .o_dbg_state     (dbg_state),
    .o_dbg_delay_cnt (dbg_cnt)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- scoreboard ----------------
  logic [W-1:0] exp_q[$];
  int n_checks = 0;
  int n_fail   = 0;
  int exp_rt   = 0;

  task automatic chk(input string name, input int got, input int exp);
    n_checks++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, required %0d (cyc %0d)", name, got, exp, cyc);
    end
  endtask

  task automatic push_ev(input logic [2:0] k, input int c, input int v);
    exp_q.push_back({k, 21'(c), 16'(v)});
  endtask

  task automatic report(input logic [2:0] k, input int v);
    logic [W-1:0] got, e;
    got = {k, 21'(cyc), 16'(v)};
    n_checks++;
    if (exp_q.size() == 0) begin
      n_fail++;
      $display("FAIL unexpected_event: got kind=%0d cyc=%0d val=%0d, required no event",
               got[39:37], got[36:16], got[15:0]);
    end else begin
      e = exp_q.pop_front();
      if (got !== e) begin
        n_fail++;
        $display("FAIL event: got kind=%0d cyc=%0d val=%0d, required kind=%0d cyc=%0d val=%0d",
                 got[39:37], got[36:16], got[15:0], e[39:37], e[36:16], e[15:0]);
      end
    end
  endtask

  // ---------------- monitor ----------------
  logic [CH-1:0] prev_outled = '0;
  logic          prev_fs     = 1'b0;
  logic          prev_to     = 1'b0;

  always @(negedge clk) begin
    if (rst) begin
      prev_outled = '0;
      prev_fs     = 1'b0;
      prev_to     = 1'b0;
    end else begin
      chk("onehot_outled", int'($countones(outled) <= 1), 1);
      chk("exclusive_flags", int'(rt_valid) + int'(false_start) + int'(timeout) <= 1 ? 1 : 0, 1);
      if (outled != '0 && prev_outled == '0) report(EV_LIT, int'(outled));
      if (rt_valid)                          report(EV_HIT, int'(rt_count));
      if (false_start && !prev_fs)           report(EV_FS, 0);
      if (timeout && !prev_to)               report(EV_TO, int'(rt_count));
      prev_outled = outled;
      prev_fs     = false_start;
      prev_to     = timeout;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic wait_until(input int c);
    while (cyc < c) @(negedge clk);
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, "_outled"}, int'(outled), 0);
    chk({tag, "_enableout"}, int'(enableout), 1);
    chk({tag, "_flags"}, int'({rt_valid, false_start, timeout}), 0);
    chk({tag, "_rt_count"}, int'(rt_count), exp_rt);
  endtask

  // Reference timing: LED edge = accept edge + max(num*SCALE, 1).
  task automatic run_round(input int n, input int s_in, input int mode, input int p);
    int e0, lit, t, s, oh;
    @(negedge clk);
    num    = NUM_W'(n);
    sel    = SEL_W'(s_in);
    enable = 1'b1;
    e0     = cyc + 1;
    t      = n * SCALE;
    lit    = e0 + ((t < 1) ? 1 : t);
    s      = (s_in >= CH) ? 0 : s_in;
    oh     = 1 << s;
    exp_rt = 0;
    @(negedge clk);
    chk("accept_rt_clear", int'(rt_count), 0);
    chk("accept_enableout", int'(enableout), 1);
    chk("accept_delay_cnt", int'(dbg_cnt), 0);
    case (mode)
      M_HIT: begin
        push_ev(EV_LIT, lit, oh);
        push_ev(EV_HIT, lit + p, p);
        wait_until(lit + p - 1);
        press = 1'b1;
        @(negedge clk);
        press  = 1'b0;
        exp_rt = p;
        @(negedge clk);
        chk("hit_hold_outled", int'(outled), oh);
        chk("hit_hold_enableout", int'(enableout), 0);
        chk("hit_hold_rt", int'(rt_count), p);
        chk("hit_pulse_end", int'(rt_valid), 0);
      end
      M_FS: begin
        push_ev(EV_FS, e0 + p, 0);
        wait_until(e0 + p - 1);
        press = 1'b1;
        @(negedge clk);
        press = 1'b0;
        @(negedge clk);
        chk("fs_flag", int'(false_start), 1);
        chk("fs_outled", int'(outled), 0);
        chk("fs_enableout", int'(enableout), 1);
      end
      M_TO: begin
        push_ev(EV_LIT, lit, oh);
        push_ev(EV_TO, lit + TIMEOUT, TIMEOUT);
        wait_until(lit + TIMEOUT + 1);
        exp_rt = TIMEOUT;
        chk("to_flag", int'(timeout), 1);
        chk("to_outled", int'(outled), oh);
        chk("to_rt", int'(rt_count), TIMEOUT);
      end
      default: begin
        if (e0 + p > lit) push_ev(EV_LIT, lit, oh);
        wait_until(e0 + p - 1);
      end
    endcase
    enable = 1'b0;
    @(negedge clk);
    chk_idle(mode == M_ABORT ? "abort" : "release");
    repeat ($urandom_range(0, 2)) @(negedge clk);
  endtask

  task automatic reset_mid_lit();
    int e0, lit;
    @(negedge clk);
    num    = NUM_W'(2);
    sel    = SEL_W'(3);
    enable = 1'b1;
    e0     = cyc + 1;
    lit    = e0 + 2 * SCALE;
    push_ev(EV_LIT, lit, 1 << 3);
    wait_until(lit + 5);
    rst = 1'b1;
    #1;
    exp_rt = 0;
    chk_idle("rst_mid_lit");
    chk("rst_mid_lit_state", int'(dbg_state), int'(IDLE));
    enable = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
  endtask

  // ---------------- main sequence ----------------
  initial begin
    int n, s, r, t, lo, mode, p;
    rst    = 1'b1;
    enable = 1'b0;
    press  = 1'b0;
    num    = '0;
    sel    = '0;
    repeat (3) @(negedge clk);
    chk_idle("reset");
    chk("reset_state", int'(dbg_state), int'(IDLE));
    rst = 1'b0;
    @(negedge clk);
    chk_idle("post_reset");

    run_round(3, 2, M_TO, 0);
    run_round(1, 1, M_HIT, 7);
    run_round(5, 0, M_FS, 50);
    run_round(0, 3, M_HIT, 4);
    run_round(127, 4, M_HIT, 2);
    run_round(4, 1, M_ABORT, 30);
    reset_mid_lit();
    run_round(2, 5, M_HIT, 3);
    run_round(1, 2, M_HIT, TIMEOUT);
    run_round(0, 1, M_FS, 1);
    run_round(2, 0, M_ABORT, 45);
    run_round(3, 7, M_HIT, 1);

    for (int i = 0; i < 30; i++) begin
      n  = $urandom_range(0, 12);
      s  = $urandom_range(0, 7);
      r  = $urandom_range(0, 9);
      t  = n * SCALE;
      lo = (t < 1) ? 1 : t;
      if (r <= 5) begin
        mode = M_HIT;
        p    = $urandom_range(1, 40);
      end else if (r <= 7) begin
        mode = M_FS;
        p    = $urandom_range(1, lo);
      end else if (r == 8) begin
        mode = M_ABORT;
        p    = $urandom_range(1, lo + 10);
      end else begin
        mode = ($urandom_range(0, 3) == 0) ? M_TO : M_HIT;
        p    = $urandom_range(1, 60);
      end
      run_round(n, s, mode, p);
    end

    repeat (3) @(negedge clk);
    chk("events_left", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    n_fail++;
    $display("FAIL watchdog: got no completion by cyc %0d, required completion", cyc);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $fatal(1, "watchdog expired");
  end

endmodule
